// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Exhaustive-vector self-check engine for an external N-input reduction
//   gate. On start it walks vec_out through 0 .. 2^N-1 in ascending order.
//   Each vector is held for SETTLE cycles and then checked for one cycle
//   against an internal reference (AND / OR / XOR / NAND). The engine
//   reports the mismatch count and the first failing vector.
//
// Parameters:
//   N       number of gate inputs (1..16)
//   SETTLE  cycles each vector is held before sampling (>= 1)
//
// Ports:
//   clk             rising-edge system clock
//   rst             synchronous active-high reset
//   start           sweep request, only honoured in IDLE
//   mode            reference function 0 AND, 1 OR, 2 XOR, 3 NAND (latched at start)
//   dut_f           output of the gate under test
//   vec_out         vector currently applied to the gate under test
//   busy            sweep in progress
//   done            one-cycle pulse when the sweep completes
//   err_cnt         number of mismatching vectors
//   fail_seen       at least one mismatch in the last sweep
//   first_fail_vec  first mismatching vector, 0 if none
//
// Optional build macro:
//   TRUTH_TABLE_STOP_ON_FAIL_EN  end the sweep at the first mismatching vector
module truth_table_sweeper #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic         dut_f,
    output logic [N-1:0] vec_out,
    output logic         busy,
    output logic         done,
    output logic [N:0]   err_cnt,
    output logic         fail_seen,
    output logic [N-1:0] first_fail_vec
);

    localparam int WW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam int CW = N + 1;

    if (N < 1 || N > 16) begin : g_bad_n
        $error("truth_table_sweeper: N must be in 1..16");
    end
    if (SETTLE < 1) begin : g_bad_settle
        $error("truth_table_sweeper: SETTLE must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_n;
    logic [1:0]    mode_q, mode_n;
    logic [WW-1:0] wait_q, wait_n;
    logic [N-1:0]  vec_n;
    logic          busy_n;
    logic          done_n;
    logic [N:0]    err_n;
    logic          fail_n;
    logic [N-1:0]  ffv_n;
    logic          ref_f;
    logic          mismatch;
    logic          last_vec;

    always_comb begin
        case (mode_q)
            2'd0:    ref_f = &vec_out;
            2'd1:    ref_f = |vec_out;
            2'd2:    ref_f = ^vec_out;
            default: ref_f = ~&vec_out;
        endcase
    end

    assign mismatch = dut_f ^ ref_f;

    // Sweep ends after the all-ones vector, or earlier on the first
    // mismatch when stop-on-fail is built in.
`ifdef TRUTH_TABLE_STOP_ON_FAIL_EN
    assign last_vec = (&vec_out) | mismatch;
`else
    assign last_vec = &vec_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mode_q         <= 2'd0;
            wait_q         <= '0;
            vec_out        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cnt        <= '0;
            fail_seen      <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            state_q        <= state_n;
            mode_q         <= mode_n;
            wait_q         <= wait_n;
            vec_out        <= vec_n;
            busy           <= busy_n;
            done           <= done_n;
            err_cnt        <= err_n;
            fail_seen      <= fail_n;
            first_fail_vec <= ffv_n;
        end
    end

    // done is registered: it rises on the edge that enters DONE and is
    // therefore high exactly while the FSM sits in DONE.
    always_comb begin
        state_n = state_q;
        mode_n  = mode_q;
        wait_n  = wait_q;
        vec_n   = vec_out;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = err_cnt;
        fail_n  = fail_seen;
        ffv_n   = first_fail_vec;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_n  = mode;
                    vec_n   = '0;
                    wait_n  = '0;
                    err_n   = '0;
                    fail_n  = 1'b0;
                    ffv_n   = '0;
                    busy_n  = 1'b1;
                    state_n = APPLY;
                end
            end
            APPLY: begin
                wait_n = wait_q + WW'(1);
                if (wait_q == WW'(SETTLE - 1)) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_n = err_cnt + CW'(1);
                    if (!fail_seen) begin
                        ffv_n  = vec_out;
                        fail_n = 1'b1;
                    end
                end
                if (last_vec) begin
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    vec_n   = vec_out + N'(1);
                    wait_n  = '0;
                    state_n = APPLY;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
